// File: rtl/usb_pkt_rx_pkg.sv
// Shared definitions for the USB FS receive packet decoder: PID codes, FSM
// states and the byte-wide LSB-first CRC5/CRC16 update functions.
package usb_pkt_rx_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_SOF   = 4'h5,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE
  } pid_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_HSHK,
    ST_DISCARD
  } state_e;

  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'b01100;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  // Bit 0 of the byte is the first bit on the wire; crc[MSB] holds the x^(n-1) term.
  function automatic logic [4:0] crc5_upd(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (data[i] ^ c[4]) c = {c[3:0], 1'b0} ^ CRC5_POLY;
      else                c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (data[i] ^ c[15]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_pkt_rx_if.sv
// UTM receive stream plus decoded-packet outputs of usb_pkt_rx.
interface usb_pkt_rx_if;
  logic [6:0]  dev_addr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_active;
  logic        rx_error;
  logic        tok_valid;
  logic [3:0]  tok_pid;
  logic [3:0]  tok_ep;
  logic        sof_valid;
  logic [10:0] sof_frame;
  logic        hs_valid;
  logic [3:0]  hs_pid;
  logic        dat_start;
  logic        dat_toggle;
  logic [7:0]  dat_byte;
  logic        dat_valid;
  logic        dat_done;
  logic        dat_ok;
  logic [6:0]  dat_len;
  logic        pid_err;
  logic        crc_err;
  logic        rx_err;

  modport master (
    output dev_addr, rx_data, rx_valid, rx_active, rx_error,
    input  tok_valid, tok_pid, tok_ep, sof_valid, sof_frame, hs_valid, hs_pid,
           dat_start, dat_toggle, dat_byte, dat_valid, dat_done, dat_ok, dat_len,
           pid_err, crc_err, rx_err
  );

  modport slave (
    input  dev_addr, rx_data, rx_valid, rx_active, rx_error,
    output tok_valid, tok_pid, tok_ep, sof_valid, sof_frame, hs_valid, hs_pid,
           dat_start, dat_toggle, dat_byte, dat_valid, dat_done, dat_ok, dat_len,
           pid_err, crc_err, rx_err
  );
endinterface

// File: rtl/usb_pkt_rx.sv
// USB 2.0 FS receive packet decoder: PID check, token/SOF/data/handshake
// decode with CRC5/CRC16 checking, address/endpoint filtering, payload streaming.
module usb_pkt_rx
  import usb_pkt_rx_pkg::*;
#(
  parameter int N_EP    = 4,
  parameter int MAX_PKT = 64
) (
  input  logic       clk_48m,
  input  logic       rst,
  usb_pkt_rx_if.slave bus
);

  state_e      state;
  pid_e        pid_q;
  logic        wait_idle;
  logic        err_seen;
  logic        err_data;
  logic        hs_extra;
  logic        ovf;
  logic [1:0]  tcnt;
  logic [1:0]  hold_cnt;
  logic [6:0]  len_cnt;
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic [10:0] tok_field;
  logic [7:0]  dat_p0;
  logic [7:0]  dat_p1;

  always_ff @(posedge clk_48m) begin
    if (rst) begin
      state          <= ST_IDLE;
      // A packet cut by reset is ignored until the line goes idle.
      wait_idle      <= 1'b1;
      err_seen       <= 1'b0;
      err_data       <= 1'b0;
      hs_extra       <= 1'b0;
      ovf            <= 1'b0;
      tcnt           <= '0;
      hold_cnt       <= '0;
      len_cnt        <= '0;
      bus.tok_valid  <= 1'b0;
      bus.tok_pid    <= '0;
      bus.tok_ep     <= '0;
      bus.sof_valid  <= 1'b0;
      bus.sof_frame  <= '0;
      bus.hs_valid   <= 1'b0;
      bus.hs_pid     <= '0;
      bus.dat_start  <= 1'b0;
      bus.dat_toggle <= 1'b0;
      bus.dat_byte   <= '0;
      bus.dat_valid  <= 1'b0;
      bus.dat_done   <= 1'b0;
      bus.dat_ok     <= 1'b0;
      bus.dat_len    <= '0;
      bus.pid_err    <= 1'b0;
      bus.crc_err    <= 1'b0;
      bus.rx_err     <= 1'b0;
    end else begin
      bus.tok_valid <= 1'b0;
      bus.sof_valid <= 1'b0;
      bus.hs_valid  <= 1'b0;
      bus.dat_start <= 1'b0;
      bus.dat_valid <= 1'b0;
      bus.dat_done  <= 1'b0;
      bus.pid_err   <= 1'b0;
      bus.crc_err   <= 1'b0;
      bus.rx_err    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!bus.rx_active) begin
            wait_idle <= 1'b0;
          end else if (!wait_idle) begin
            state    <= ST_PID;
            err_seen <= 1'b0;
            err_data <= 1'b0;
            hs_extra <= 1'b0;
            ovf      <= 1'b0;
            tcnt     <= '0;
            hold_cnt <= '0;
            len_cnt  <= '0;
            crc5     <= CRC5_INIT;
            crc16    <= CRC16_INIT;
          end
        end

        ST_PID: begin
          if (!bus.rx_active) begin
            state <= ST_IDLE;
          end else if (bus.rx_error) begin
            state    <= ST_DISCARD;
            err_seen <= 1'b1;
          end else if (bus.rx_valid) begin
            pid_q <= pid_e'(bus.rx_data[3:0]);
            if (bus.rx_data[7:4] != ~bus.rx_data[3:0]) begin
              bus.pid_err <= 1'b1;
              state       <= ST_DISCARD;
            end else begin
              case (pid_e'(bus.rx_data[3:0]))
                PID_OUT, PID_IN, PID_SETUP, PID_SOF: state <= ST_TOKEN;
                PID_DATA0, PID_DATA1: begin
                  state          <= ST_DATA;
                  bus.dat_start  <= 1'b1;
                  bus.dat_toggle <= bus.rx_data[3];
                end
                PID_ACK, PID_NAK, PID_STALL: state <= ST_HSHK;
                default: begin
                  bus.pid_err <= 1'b1;
                  state       <= ST_DISCARD;
                end
              endcase
            end
          end
        end

        ST_TOKEN: begin
          if (!bus.rx_active) begin
            state <= ST_IDLE;
            if (tcnt != 2'd2 || crc5 != CRC5_RESID) begin
              bus.crc_err <= 1'b1;
            end else if (pid_q == PID_SOF) begin
              bus.sof_valid <= 1'b1;
              bus.sof_frame <= tok_field;
            end else if (tok_field[6:0] == bus.dev_addr &&
                         {1'b0, tok_field[10:7]} < 5'(N_EP)) begin
              bus.tok_valid <= 1'b1;
              bus.tok_pid   <= pid_q;
              bus.tok_ep    <= tok_field[10:7];
            end
          end else if (bus.rx_error) begin
            state    <= ST_DISCARD;
            err_seen <= 1'b1;
          end else if (bus.rx_valid) begin
            crc5 <= crc5_upd(crc5, bus.rx_data);
            if (tcnt == 2'd0) tok_field[7:0]  <= bus.rx_data;
            if (tcnt == 2'd1) tok_field[10:8] <= bus.rx_data[2:0];
            if (tcnt != 2'd3) tcnt <= tcnt + 2'd1;
          end
        end

        ST_DATA: begin
          if (!bus.rx_active) begin
            state        <= ST_IDLE;
            bus.dat_done <= 1'b1;
            bus.dat_len  <= len_cnt;
            bus.dat_ok   <= (hold_cnt == 2'd2) && (crc16 == CRC16_RESID) && !ovf;
            bus.crc_err  <= (hold_cnt == 2'd2) && (crc16 != CRC16_RESID);
          end else if (bus.rx_error) begin
            state    <= ST_DISCARD;
            err_seen <= 1'b1;
            err_data <= 1'b1;
          end else if (bus.rx_valid) begin
            crc16 <= crc16_upd(crc16, bus.rx_data);
            // Two-byte hold: the CRC bytes are never forwarded.
            dat_p0 <= dat_p1;
            dat_p1 <= bus.rx_data;
            if (hold_cnt != 2'd2) begin
              hold_cnt <= hold_cnt + 2'd1;
            end else if (len_cnt == 7'(MAX_PKT)) begin
              ovf <= 1'b1;
            end else begin
              bus.dat_valid <= 1'b1;
              bus.dat_byte  <= dat_p0;
              len_cnt       <= len_cnt + 7'd1;
            end
          end
        end

        ST_HSHK: begin
          if (!bus.rx_active) begin
            state <= ST_IDLE;
            if (hs_extra) begin
              bus.pid_err <= 1'b1;
            end else begin
              bus.hs_valid <= 1'b1;
              bus.hs_pid   <= pid_q;
            end
          end else if (bus.rx_error) begin
            state    <= ST_DISCARD;
            err_seen <= 1'b1;
          end else if (bus.rx_valid) begin
            hs_extra <= 1'b1;
          end
        end

        ST_DISCARD: begin
          if (!bus.rx_active) begin
            state      <= ST_IDLE;
            bus.rx_err <= err_seen;
            if (err_data) begin
              bus.dat_done <= 1'b1;
              bus.dat_ok   <= 1'b0;
              bus.dat_len  <= len_cnt;
            end
          end else if (bus.rx_error) begin
            err_seen <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
